vector_operand_dispatch: RTL and testbench



---
 rtl/vector_operand_dispatch.sv | 114 +++++++++++
 tb/tb_vector_operand_dispatch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_dispatch.sv
// Reads vs2/vs1 from the VRF for one accepted op, then holds the operands until the unit takes them.
// Issue to exec_valid in 2 cycles; issue stalls on scoreboard hazards or while an op is in flight.
package vector_operand_dispatch_pkg;
  typedef struct packed {
    logic [5:0] funct6;
    logic [2:0] funct3;
    logic [2:0] sew;
    logic       vm;
    logic [2:0] lmul;
  } execution_vector_t;
endpackage

module vector_operand_dispatch
  import vector_operand_dispatch_pkg::*;
#(
  parameter int VLEN      = 128,
  parameter int NUM_VREGS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  execution_vector_t     issue_execution_vector,
  input  logic [ADDR_W-1:0]     issue_vs2_addr,
  input  logic [ADDR_W-1:0]     issue_vs1_addr,
  input  logic [ADDR_W-1:0]     issue_vd_addr,
  output logic [ADDR_W-1:0]     vrf_rd_addr_a,
  output logic [ADDR_W-1:0]     vrf_rd_addr_b,
  input  logic [VLEN-1:0]       vrf_rd_data_a,
  input  logic [VLEN-1:0]       vrf_rd_data_b,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output execution_vector_t     execution_vector,
  output logic [VLEN-1:0]       vs2,
  output logic [VLEN-1:0]       vs1,
  output logic [ADDR_W-1:0]     exec_vd_addr,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_addr,
  output logic [NUM_VREGS-1:0]  busy_mask,
  output logic [31:0]           dispatch_count,
  output logic [31:0]           stall_count
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t                state, state_next;
  logic                  hazard;
  logic                  accept;
  logic [NUM_VREGS-1:0]  busy_next;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Hazard uses registered busy only; a writeback this cycle frees the register next cycle.
  always_comb begin
    state_next  = state;
    issue_ready = 1'b0;
    exec_valid  = 1'b0;
    hazard      = busy_mask[issue_vs2_addr] | busy_mask[issue_vs1_addr] | busy_mask[issue_vd_addr];
    case (state)
      IDLE: begin
        issue_ready = ~hazard & ~reset;
        if (issue_valid && issue_ready) state_next = READ;
      end
      READ: state_next = HOLD;
      HOLD: begin
        exec_valid = 1'b1;
        if (exec_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = issue_valid & issue_ready;

  // Set is applied after clear so a same-index set wins.
  always_comb begin
    busy_next = busy_mask;
    if (wb_valid) busy_next[wb_addr] = 1'b0;
    if (accept)   busy_next[issue_vd_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_mask        <= '0;
      execution_vector <= '0;
      vrf_rd_addr_a    <= '0;
      vrf_rd_addr_b    <= '0;
      exec_vd_addr     <= '0;
      vs2              <= '0;
      vs1              <= '0;
      dispatch_count   <= '0;
      stall_count      <= '0;
    end else begin
      busy_mask <= busy_next;
      if (accept) begin
        execution_vector <= issue_execution_vector;
        vrf_rd_addr_a    <= issue_vs2_addr;
        vrf_rd_addr_b    <= issue_vs1_addr;
        exec_vd_addr     <= issue_vd_addr;
      end
      if (state == READ) begin
        vs2 <= vrf_rd_data_a;
        vs1 <= vrf_rd_data_b;
      end
      if (exec_valid && exec_ready) dispatch_count <= dispatch_count + 32'd1;
      if (issue_valid && !issue_ready) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_vector_operand_dispatch.sv
// Directed bench: table of full dispatches plus hand sequences for stalls, hold, set-wins and reset.
module tb_vector_operand_dispatch;
  import vector_operand_dispatch_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  execution_vector_t issue_execution_vector;
  logic [4:0]        issue_vs2_addr, issue_vs1_addr, issue_vd_addr;
  logic [4:0]        vrf_rd_addr_a, vrf_rd_addr_b;
  logic [127:0]      vrf_rd_data_a, vrf_rd_data_b;
  logic              exec_valid;
  logic              exec_ready;
  execution_vector_t execution_vector;
  logic [127:0]      vs2, vs1;
  logic [4:0]        exec_vd_addr;
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [31:0]       busy_mask;
  logic [31:0]       dispatch_count, stall_count;

  logic [127:0]      vrf [32];
  logic [127:0]      pert;
  int                errors = 0;
  int                checks = 0;

  always #5 clock = ~clock;

  assign vrf_rd_data_a = vrf[vrf_rd_addr_a] ^ pert;
  assign vrf_rd_data_b = vrf[vrf_rd_addr_b] ^ pert;

  vector_operand_dispatch dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_execution_vector(issue_execution_vector),
    .issue_vs2_addr(issue_vs2_addr), .issue_vs1_addr(issue_vs1_addr), .issue_vd_addr(issue_vd_addr),
    .vrf_rd_addr_a(vrf_rd_addr_a), .vrf_rd_addr_b(vrf_rd_addr_b),
    .vrf_rd_data_a(vrf_rd_data_a), .vrf_rd_data_b(vrf_rd_data_b),
    .exec_valid(exec_valid), .exec_ready(exec_ready),
    .execution_vector(execution_vector), .vs2(vs2), .vs1(vs1), .exec_vd_addr(exec_vd_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_mask(busy_mask), .dispatch_count(dispatch_count), .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]   vs2, vs1, vd;
    logic [15:0]  ev;
    logic [127:0] ea, eb;
    bit           do_wb;
    logic [31:0]  busy_acc, busy_end;
  } vec_t;

  vec_t tbl [4];

  task automatic drive_issue(input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] d,
                             input logic [15:0] ev);
    issue_valid            = 1'b1;
    issue_vs2_addr         = a2;
    issue_vs1_addr         = a1;
    issue_vd_addr          = d;
    issue_execution_vector = execution_vector_t'(ev);
  endtask

  initial begin
    tbl[0] = '{5'd3,  5'd4,  5'd5,  16'h1234, {16{8'hAA}}, {16{8'h55}}, 1'b0, 32'h020, 32'h020};
    tbl[1] = '{5'd1,  5'd2,  5'd10, 16'h00F1, {16{8'h01}}, {16{8'h02}}, 1'b1, 32'h420, 32'h020};
    tbl[2] = '{5'd9,  5'd9,  5'd9,  16'hA5C3, {16{8'h09}}, {16{8'h09}}, 1'b1, 32'h220, 32'h020};
    tbl[3] = '{5'd31, 5'd30, 5'd8,  16'h7E01, {16{8'h1F}}, {16{8'h1E}}, 1'b0, 32'h120, 32'h120};

    for (int i = 0; i < 32; i++) vrf[i] = {16{8'(i)}};
    vrf[3] = {16{8'hAA}};
    vrf[4] = {16{8'h55}};
    pert = '0;

    reset = 1'b1; issue_valid = 1'b0; issue_execution_vector = '0;
    issue_vs2_addr = '0; issue_vs1_addr = '0; issue_vd_addr = '0;
    exec_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0;

    repeat (3) @(negedge clock);
    chk("rst_issue_ready_in_reset", issue_ready, 0);
    chk("rst_exec_valid", exec_valid, 0);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy_mask, 0);
    chk("rst_dispatch", dispatch_count, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_vs2", vs2, 0);
    chk("rst_vd", exec_vd_addr, 0);
    chk("rst_issue_ready", issue_ready, 1);

    // Full dispatches with exec_ready held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive_issue(tbl[i].vs2, tbl[i].vs1, tbl[i].vd, tbl[i].ev);
      #1 chk("tbl_accept_ready", issue_ready, 1);
      @(negedge clock);
      issue_valid = 1'b0;
      chk("tbl_rd_addr_a", vrf_rd_addr_a, tbl[i].vs2);
      chk("tbl_rd_addr_b", vrf_rd_addr_b, tbl[i].vs1);
      chk("tbl_busy_accept", busy_mask, tbl[i].busy_acc);
      chk("tbl_read_not_ready", issue_ready, 0);
      chk("tbl_read_no_valid", exec_valid, 0);
      @(negedge clock);
      chk("tbl_exec_valid", exec_valid, 1);
      chk("tbl_vs2", vs2, tbl[i].ea);
      chk("tbl_vs1", vs1, tbl[i].eb);
      chk("tbl_vd", exec_vd_addr, tbl[i].vd);
      chk("tbl_ev", execution_vector, tbl[i].ev);
      @(negedge clock);
      chk("tbl_exec_drop", exec_valid, 0);
      chk("tbl_dispatch", dispatch_count, i + 1);
      if (tbl[i].do_wb) begin
        wb_valid = 1'b1;
        wb_addr  = tbl[i].vd;
      end
      @(negedge clock);
      wb_valid = 1'b0;
      chk("tbl_busy_end", busy_mask, tbl[i].busy_end);
    end
    chk("tbl_no_stalls", stall_count, 0);

    // Source busy for 4 cycles; writeback in the 4th frees it the cycle after.
    drive_issue(5'd5, 5'd6, 5'd5, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      #1 chk("haz_ready_low", issue_ready, 0);
      if (k == 3) begin
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
      end
      @(negedge clock);
      wb_valid = 1'b0;
    end
    #1;
    chk("haz_ready_rise", issue_ready, 1);
    chk("haz_stall_count", stall_count, 4);
    chk("haz_busy_cleared", busy_mask, 32'h100);
    exec_ready = 1'b0;
    @(negedge clock);
    issue_valid = 1'b0;
    chk("haz_busy_reset", busy_mask, 32'h120);

    // Operands held stable in HOLD while the VRF data wiggles.
    @(negedge clock);
    for (int j = 0; j < 6; j++) begin
      pert = {$urandom, $urandom, $urandom, $urandom};
      chk("hold_valid", exec_valid, 1);
      chk("hold_vs2", vs2, {16{8'h05}});
      chk("hold_vs1", vs1, {16{8'h06}});
      chk("hold_vd", exec_vd_addr, 5);
      chk("hold_ev", execution_vector, 16'hBEEF);
      chk("hold_not_ready", issue_ready, 0);
      chk("hold_dispatch", dispatch_count, 4);
      @(negedge clock);
    end
    pert = '0;
    exec_ready = 1'b1;
    @(negedge clock);
    chk("hold_dispatch_once", dispatch_count, 5);
    chk("hold_released", exec_valid, 0);

    // Accept vd=7 while writing back 7: set wins.
    drive_issue(5'd1, 5'd2, 5'd7, 16'h0007);
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    #1 chk("setwin_ready", issue_ready, 1);
    @(negedge clock);
    issue_valid = 1'b0;
    wb_valid = 1'b0;
    chk("setwin_busy", busy_mask, 32'h1A0);
    repeat (2) @(negedge clock);
    chk("setwin_dispatch", dispatch_count, 6);

    // Retire 7, write back a non-busy register, then retire 5.
    wb_valid = 1'b1; wb_addr = 5'd7;
    @(negedge clock);
    wb_addr = 5'd12;
    @(negedge clock);
    chk("wb_nonbusy_noeffect", busy_mask, 32'h120);
    wb_addr = 5'd5;
    @(negedge clock);
    wb_valid = 1'b0;
    chk("wb_clear5", busy_mask, 32'h100);

    // Reset while parked in HOLD.
    exec_ready = 1'b0;
    drive_issue(5'd1, 5'd2, 5'd5, 16'h0F0F);
    @(negedge clock);
    issue_valid = 1'b0;
    @(negedge clock);
    chk("rsth_in_hold", exec_valid, 1);
    chk("rsth_busy_before", busy_mask, 32'h120);
    reset = 1'b1;
    @(negedge clock);
    chk("rsth_exec_valid", exec_valid, 0);
    chk("rsth_busy", busy_mask, 0);
    chk("rsth_dispatch", dispatch_count, 0);
    chk("rsth_stall", stall_count, 0);
    chk("rsth_vs2", vs2, 0);
    chk("rsth_vs1", vs1, 0);
    chk("rsth_vd", exec_vd_addr, 0);
    chk("rsth_ev", execution_vector, 0);
    chk("rsth_addr_a", vrf_rd_addr_a, 0);
    chk("rsth_ready_in_reset", issue_ready, 0);
    reset = 1'b0;
    exec_ready = 1'b1;
    #1 chk("rsth_ready_after", issue_ready, 1);
    @(negedge clock);
    chk("rsth_idle", exec_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
